// File: rtl/ex_mem_issue.sv
// ex_mem_issue
//   Issues EX-stage loads/stores onto an SRAM-style split request/response
//   bus and returns the aligned, extended load data (or a store ack) to MEM.
//   Requests in flight are tracked in an in-order FIFO. A pipeline flush
//   cancels every tracked entry. Cancelled entries still consume their
//   data_ok, but they produce no response.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   flush                 pipeline flush from WB (exception / ertn)
//   req_*                 memory op presented by EX
//   req_done, req_ale     op retired this cycle / misaligned address
//   data_sram_*           bus request side (req/addr_ok) and response side
//                         (data_ok/rdata)
//   rsp_*                 registered one-cycle response to MEM
//   pending               live (non-cancelled) outstanding requests
//   proto_err             sticky: data_ok seen with nothing outstanding
module ex_mem_issue #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              req_done,
    output logic              req_ale,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [3:0]        data_sram_wstrb,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [31:0]       data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    output logic              rsp_valid,
    output logic              rsp_wr,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [31:0]       rsp_rdata,
    output logic [CW-1:0]     pending,
    output logic              proto_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    typedef struct packed {
        logic             wr;
        logic [1:0]       size;
        logic             uns;
        logic [1:0]       lo;
        logic [TAG_W-1:0] tag;
        logic             cancel;
    } entry_t;

    entry_t           fifo_q [DEPTH];
    entry_t           fifo_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    canc_q, canc_d;
    logic             proto_err_q, proto_err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_wr_q, rsp_wr_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;

    logic             push, pop;
    entry_t           head;
    logic [31:0]      shifted;
    logic [31:0]      load_val;

    // Pointers wrap at DEPTH rather than at a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Request decode. Size 3 is not a legal access, so it is reported as misaligned.
    always_comb begin
        req_ale = req_valid & ((req_size == 2'd1 & req_addr[0]) |
                               (req_size == 2'd2 & req_addr[1:0] != 2'b00) |
                               (req_size == 2'd3));
        // Occupancy includes cancelled entries that are still waiting for their data_ok.
        data_sram_req = req_valid & ~req_ale & ~flush & (cnt_q < DEPTH_C);
        req_done      = req_valid & ~flush & (req_ale | (data_sram_req & data_sram_addr_ok));

        data_sram_wr   = req_wr;
        data_sram_size = req_size;
        data_sram_addr = req_addr;

        data_sram_wstrb = 4'b0000;
        data_sram_wdata = req_wdata;
        case (req_size)
            2'd0: begin
                data_sram_wdata = {4{req_wdata[7:0]}};
                if (req_wr) data_sram_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'd1: begin
                data_sram_wdata = {2{req_wdata[15:0]}};
                if (req_wr) data_sram_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                if (req_wr) data_sram_wstrb = 4'b1111;
            end
            default: begin
                data_sram_wstrb = 4'b0000;
            end
        endcase
    end

    // Response data for the FIFO head: pick the lane from the low address bits.
    always_comb begin
        head    = fifo_q[rptr_q];
        shifted = data_sram_rdata >> {head.lo, 3'b000};
        case (head.size)
            2'd0:    load_val = {{24{~head.uns & shifted[7]}}, shifted[7:0]};
            2'd1:    load_val = {{16{~head.uns & shifted[15]}}, shifted[15:0]};
            default: load_val = data_sram_rdata;
        endcase
    end

    // FIFO bookkeeping. Cancelled entries are always the oldest ones,
    // because a flush cancels everything and also blocks that cycle's push.
    // This lets a single counter track the cancelled entries.
    always_comb begin
        push = data_sram_req & data_sram_addr_ok;
        pop  = data_sram_data_ok & (cnt_q != '0);

        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) fifo_d[i].cancel = 1'b1;
        end
        if (push) begin
            fifo_d[wptr_q] = '{wr: req_wr, size: req_size, uns: req_unsigned,
                               lo: req_addr[1:0], tag: req_tag, cancel: 1'b0};
            wptr_d = ptr_inc(wptr_q);
        end
        if (pop) rptr_d = ptr_inc(rptr_q);

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (flush) canc_d = cnt_q - CW'(pop);
        else       canc_d = canc_q - CW'(pop & head.cancel);

        proto_err_d = proto_err_q | (data_sram_data_ok & (cnt_q == '0));

        // A head that pops in the flush cycle is treated as cancelled.
        rsp_valid_d = pop & ~head.cancel & ~flush;
        rsp_wr_d    = rsp_wr_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_rdata_d = rsp_rdata_q;
        if (rsp_valid_d) begin
            rsp_wr_d    = head.wr;
            rsp_tag_d   = head.tag;
            rsp_rdata_d = head.wr ? 32'h0 : load_val;
        end
    end

    // All state is cleared by reset, which takes priority over flush, push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            canc_q      <= '0;
            proto_err_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            fifo_q      <= fifo_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            canc_q      <= canc_d;
            proto_err_q <= proto_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign pending   = cnt_q - canc_q;
    assign proto_err = proto_err_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
